// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among functional-unit results,
// registered broadcast of the winner's tag and data plus a saturating broadcast count.
module cdb_arbiter #(
  parameter int NUM_UNITS = 5,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_UNITS-1:0]        req_valid,
  input  logic [NUM_UNITS*DATA_W-1:0] req_result,
  output logic [NUM_UNITS-1:0]        grant,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [CNT_W-1:0]            bcast_count
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0] grant_q, grant_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]     cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;
  logic [CNT_W-1:0]     bcast_count_q, bcast_count_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_UNITS-1:0] elig;
  logic                 found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W:0]       idx_sum;
  logic [PTR_W-1:0]     idx;

  always_comb begin
    // The unit granted last cycle still holds req_valid, so it is masked out.
    elig    = req_valid & ~grant_q;
    found   = 1'b0;
    win_idx = '0;
    idx_sum = '0;
    idx     = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (idx_sum >= (PTR_W+1)'(NUM_UNITS)) begin
        idx_sum = idx_sum - (PTR_W+1)'(NUM_UNITS);
      end
      idx = idx_sum[PTR_W-1:0];
      if (!found && elig[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    grant_d       = '0;
    cdb_valid_d   = 1'b0;
    cdb_tag_d     = '0;
    cdb_data_d    = '0;
    bcast_count_d = bcast_count_q;
    rr_ptr_d      = rr_ptr_q;
    if (found) begin
      grant_d     = NUM_UNITS'(1) << win_idx;
      cdb_valid_d = 1'b1;
      cdb_tag_d   = TAG_W'(win_idx) + TAG_W'(1);
      for (int j = 0; j < NUM_UNITS; j++) begin
        if (win_idx == PTR_W'(j)) begin
          cdb_data_d = req_result[j*DATA_W +: DATA_W];
        end
      end
      rr_ptr_d = (win_idx == PTR_W'(NUM_UNITS-1)) ? '0 : win_idx + PTR_W'(1);
      if (bcast_count_q != {CNT_W{1'b1}}) begin
        bcast_count_d = bcast_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q       <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_tag_q     <= '0;
      cdb_data_q    <= '0;
      bcast_count_q <= '0;
      rr_ptr_q      <= '0;
    end else begin
      grant_q       <= grant_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_tag_q     <= cdb_tag_d;
      cdb_data_q    <= cdb_data_d;
      bcast_count_q <= bcast_count_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign grant       = grant_q;
  assign cdb_valid   = cdb_valid_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_data    = cdb_data_q;
  assign bcast_count = bcast_count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: behavioural round-robin model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [4:0]   req_valid = '0;
  logic [159:0] req_result = '0;

  logic [4:0]   grant, grant4;
  logic         cdb_valid, cdb_valid4;
  logic [2:0]   cdb_tag, cdb_tag4;
  logic [31:0]  cdb_data, cdb_data4;
  logic [15:0]  bcast_count;
  logic [3:0]   bcast_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_result(req_result),
    .grant(grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .bcast_count(bcast_count)
  );

  cdb_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_result(req_result),
    .grant(grant4), .cdb_valid(cdb_valid4), .cdb_tag(cdb_tag4),
    .cdb_data(cdb_data4), .bcast_count(bcast_count4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: which unit holds the bus this cycle (-1 = none), rotation start, counts.
  int          m_idx  = -1;
  int          m_ptr  = 0;
  int          m_cnt  = 0;
  int          m_cnt4 = 0;
  logic [31:0] m_data = '0;

  always @(posedge clk) begin
    int w;
    int j;
    w = -1;
    if (reset) begin
      m_idx = -1; m_ptr = 0; m_cnt = 0; m_cnt4 = 0; m_data = '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        j = (m_ptr + k) % 5;
        if (w < 0 && req_valid[j] && j != m_idx) w = j;
      end
      m_idx = w;
      if (w >= 0) begin
        m_data = req_result[w*32 +: 32];
        m_ptr  = (w + 1) % 5;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end else begin
        m_data = '0;
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] eg;
    eg = (m_idx < 0) ? 5'd0 : (5'd1 << m_idx);
    check("model_grant", 64'(grant), 64'(eg));
    check("model_valid", 64'(cdb_valid), 64'(m_idx >= 0));
    check("model_tag", 64'(cdb_tag), 64'((m_idx < 0) ? 0 : m_idx + 1));
    check("model_data", 64'(cdb_data), 64'(m_data));
    check("model_count", 64'(bcast_count), 64'(m_cnt));
    check("model_grant4", 64'(grant4), 64'(eg));
    check("model_count4", 64'(bcast_count4), 64'(m_cnt4));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_res(input int i, input logic [31:0] v);
    req_result[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; req_result = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_bcast(input string name, input int tag, input logic [31:0] data);
    check({name, "_valid"}, 64'(cdb_valid), 64'(1));
    check({name, "_tag"}, 64'(cdb_tag), 64'(tag));
    check({name, "_data"}, 64'(cdb_data), 64'(data));
  endtask

  initial begin
    // 1: single ADD2 request
    do_reset();
    check("reset_grant", 64'(grant), 64'(0));
    check("reset_count", 64'(bcast_count), 64'(0));
    step(); req_valid[1] = 1'b1; set_res(1, 32'h11);
    step();
    check("t1_grant", 64'(grant), 64'(5'b00010));
    expect_bcast("t1", 2, 32'h11);
    req_valid[1] = 1'b0;
    step();
    check("t1_idle", 64'(cdb_valid), 64'(0));

    // 2: all five at once
    do_reset();
    step();
    req_valid = 5'b11111;
    for (int i = 0; i < 5; i++) set_res(i, 32'hA0 + i);
    for (int c = 0; c < 5; c++) begin
      step();
      expect_bcast("t2", c + 1, 32'hA0 + c);
      req_valid = req_valid & ~grant;
    end
    step();
    check("t2_idle", 64'(cdb_valid), 64'(0));
    check("t2_count", 64'(bcast_count), 64'(5));

    // 3: fairness after ADD3
    do_reset();
    step(); req_valid[2] = 1'b1; set_res(2, 32'h33);
    step(); expect_bcast("t3a", 3, 32'h33); req_valid[2] = 1'b0;
    step();
    req_valid[0] = 1'b1; set_res(0, 32'hB0);
    req_valid[4] = 1'b1; set_res(4, 32'hB4);
    step(); expect_bcast("t3b", 5, 32'hB4); req_valid = req_valid & ~grant;
    step(); expect_bcast("t3c", 1, 32'hB0); req_valid = req_valid & ~grant;
    step(); check("t3_idle", 64'(cdb_valid), 64'(0));

    // 4: MUL1 masking; first drop right after grant cycle, then hold one more cycle
    do_reset();
    step(); req_valid[3] = 1'b1; set_res(3, 32'hC3);
    step(); check("t4_grant", 64'(grant), 64'(5'b01000)); expect_bcast("t4a", 4, 32'hC3);
    step(); check("t4_masked", 64'(cdb_valid), 64'(0)); req_valid[3] = 1'b0;
    step(); check("t4_idle", 64'(cdb_valid), 64'(0));
    req_valid[3] = 1'b1; set_res(3, 32'hC4);
    step(); expect_bcast("t4b", 4, 32'hC4);
    step(); check("t4_masked2", 64'(cdb_valid), 64'(0));
    step(); expect_bcast("t4c", 4, 32'hC4); req_valid[3] = 1'b0;
    step(); check("t4_idle2", 64'(cdb_valid), 64'(0));

    // 5: reset during a broadcast
    do_reset();
    step();
    req_valid[0] = 1'b1; set_res(0, 32'hD0);
    req_valid[3] = 1'b1; set_res(3, 32'hD3);
    step(); expect_bcast("t5a", 1, 32'hD0); reset = 1'b1;
    step();
    check("t5_grant", 64'(grant), 64'(0));
    check("t5_valid", 64'(cdb_valid), 64'(0));
    check("t5_tag", 64'(cdb_tag), 64'(0));
    check("t5_data", 64'(cdb_data), 64'(0));
    check("t5_count", 64'(bcast_count), 64'(0));
    reset = 1'b0;
    step(); expect_bcast("t5b", 1, 32'hD0);
    req_valid = '0;
    step();

    // 6: saturation of the 4-bit counter
    do_reset();
    for (int n = 0; n < 20; n++) begin
      bit got;
      got = 1'b0;
      step(); req_valid[2] = 1'b1; set_res(2, 32'(n));
      for (int k = 0; k < 5 && !got; k++) begin
        step();
        if (grant[2]) got = 1'b1;
      end
      if (!got) check("t6_timeout", 64'(0), 64'(1));
      req_valid[2] = 1'b0;
      if (n == 14) check("t6_sat15", 64'(bcast_count4), 64'(15));
    end
    step();
    check("t6_hold15", 64'(bcast_count4), 64'(15));
    check("t6_count20", 64'(bcast_count), 64'(20));

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
